kernel_irq_responder: RTL and testbench
=======================================

Name: kernel_irq_responder

Overview:
- Servicing end of the kernel interrupt handshake. Watches `kernel_irq` and emits the `dma_ack` and `kernel_ack` pulses in the order the interrupt aggregator needs to clear it: `dma_ack` first, then `kernel_ack`.
- Pulses are stretched and separated so a 3-stage synchroniser with edge detect on the far side catches every edge.
- Sits beside the DMA result-writeback path in the `dma_axi_aclk` domain.
- Provides a timeout/retry mechanism, a sticky error flag and a serviced-interrupt counter.

Parameters:
- PULSE_LEN, 4, high time of each ack pulse in clocks (min 4).
- GAP_LEN, 4, low time between `dma_ack` fall and `kernel_ack` rise (min 4).
- TIMEOUT, 64, clocks in WAIT_CLR before a retry is declared.
- MAX_RETRY, 3, retries allowed before entering ERROR.
- CNT_W, 16, width of `irq_count`.

Ports:
- `dma_axi_aclk`  in  1  clock.
- `dma_axi_aresetn`  in  1  reset; asynchronous assert, active-low.
- `enable`  in  1  allows servicing to start; sampled only in IDLE.
- `kernel_irq`  in  1  interrupt level from the aggregator; treated as asynchronous.
- `dma_done`  in  1  one-cycle pulse: DMA has finished moving kernel results.
- `err_clr`  in  1  one-cycle pulse; clears ERROR.
- `dma_ack`  out  1  registered ack pulse to the aggregator.
- `kernel_ack`  out  1  registered ack pulse to the aggregator.
- `busy`  out  1  high in any state other than IDLE and ERROR.
- `err`  out  1  sticky; high in ERROR.
- `irq_count`  out  CNT_W  count of successfully cleared interrupts; wraps.

Behaviour:
- Reset (async, immediate) drives all outputs to 0. State = IDLE; all timers, the retry count and `dma_pend` cleared. Reset mid-pulse drops the ack at once.
- Input synchronisation:
  - `kernel_irq` passes through a 2-FF synchroniser; `irq_s` is its output.
  - `dma_done` is synchronous to `dma_axi_aclk`.
- `dma_pend` flag:
  - Set on `dma_done` in any state; cleared when WAIT_DMA consumes it.
  - If set and clear occur in the same cycle, set wins, so a second completion is kept.
- All outputs are registered directly from state; no glitches.
- States and transitions:
  - IDLE: `irq_s`=1 and `enable`=1 -> WAIT_DMA. Retry count reset to 0. Level-sensitive, so an interrupt already high when `enable` rises is serviced.
  - WAIT_DMA: `dma_pend`=1 -> DMA_ACK and clear `dma_pend`. No timeout; waits indefinitely.
  - DMA_ACK: `dma_ack`=1 for exactly PULSE_LEN cycles -> GAP.
  - GAP: both acks 0 for GAP_LEN cycles -> KERN_ACK.
  - KERN_ACK: `kernel_ack`=1 for exactly PULSE_LEN cycles -> WAIT_CLR. Timer loaded with 0.
  - WAIT_CLR, evaluated in this priority order:
    - `irq_s`=0 -> IDLE, and `irq_count` increments.
    - Timer == TIMEOUT-1 with retry count < MAX_RETRY -> retry count +1, go to DMA_ACK. The full pair is re-sent because the aggregator drops its DMA-ack flag on every `kernel_ack` edge.
    - Timer == TIMEOUT-1 with retry count == MAX_RETRY -> ERROR.
  - ERROR: `err`=1, both acks 0. `err_clr` -> IDLE with `err`=0. If `kernel_irq` is still high, servicing restarts on the next cycle.
- Latency: with `dma_pend` already set, `dma_ack` first reads 1 in the 4th rising clock after `kernel_irq` is first sampled high: 2 sync, 1 IDLE, 1 WAIT_DMA.
- Simultaneous events:
  - `irq_s` fall on the timeout cycle counts as success.
  - `enable` deasserted mid-sequence does not abort; the sequence completes.
- Width rules:
  - Timers are $clog2(max(PULSE_LEN, GAP_LEN, TIMEOUT))+1 bits.
  - The retry counter is $clog2(MAX_RETRY+1) bits.
  - `irq_count` wraps from all-ones to 0.

Decomposition:
- Package `kernel_irq_pkg`: state enum (IDLE, WAIT_DMA, DMA_ACK, GAP, KERN_ACK, WAIT_CLR, ERROR) and the minimum PULSE_LEN/GAP_LEN constants (4) as localparams.
- One sub-module, `sync_2ff` (1-bit double-flop synchroniser with async active-low reset), instantiated for `kernel_irq`.

Test Plan:
- Basic service: `enable`=1, `dma_done` pulse, then `kernel_irq`↑.
  - `dma_ack` high cycles 4–7 after the irq edge, low 8–11, `kernel_ack` high 12–15.
  - Model drops irq at cycle 20 -> `irq_count`=1, `busy`=0.
- DMA late: `kernel_irq`↑, then `dma_done` 50 cycles later -> no ack while waiting; `dma_ack` rises 2 cycles after `dma_done`.
- Retry: irq held high forever with TIMEOUT=64, MAX_RETRY=3.
  - 4 `dma_ack`/`kernel_ack` pairs, then `err`=1 and `irq_count` unchanged.
  - `err_clr` -> servicing restarts.
- Double completion: `dma_done` on the same cycle WAIT_DMA consumes the flag -> `dma_pend` stays 1; the next interrupt acks without a new `dma_done`.
- Reset mid-`kernel_ack` (cycle 13): outputs 0 asynchronously; after release, state IDLE and `irq_count`=0.
- Counter wrap: CNT_W=2, 5 full services -> `irq_count` sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/kernel_irq_responder_pkg.sv
// Shared types and constants for the kernel interrupt responder.
package kernel_irq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DMA,
    DMA_ACK,
    GAP,
    KERN_ACK,
    WAIT_CLR,
    ERROR
  } state_t;

  // Far-side 3-stage synchroniser with edge detect needs at least this many
  // clocks of high and low time to see every edge.
  localparam int MIN_PULSE_LEN = 4;
  localparam int MIN_GAP_LEN   = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/kernel_irq_responder_if.sv
// Handshake bundle between the interrupt aggregator side and the responder.
interface kernel_irq_responder_if #(
  parameter int CNT_W = 16
);
  logic             enable;
  logic             kernel_irq;
  logic             dma_done;
  logic             err_clr;
  logic             dma_ack;
  logic             kernel_ack;
  logic             busy;
  logic             err;
  logic [CNT_W-1:0] irq_count;

  modport master (
    output enable, kernel_irq, dma_done, err_clr,
    input  dma_ack, kernel_ack, busy, err, irq_count
  );

  modport slave (
    input  enable, kernel_irq, dma_done, err_clr,
    output dma_ack, kernel_ack, busy, err, irq_count
  );
endinterface

// File: rtl/kernel_irq_responder_sync_2ff.sv
// Single-bit double-flop synchroniser for an asynchronous level input.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/kernel_irq_responder.sv
// Servicing end of the kernel interrupt handshake: waits for the DMA result
// writeback, then emits a stretched dma_ack followed by a stretched
// kernel_ack, retrying the pair if the aggregator does not drop the interrupt.
module kernel_irq_responder
  import kernel_irq_pkg::*;
#(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 4,
  parameter int TIMEOUT   = 64,
  parameter int MAX_RETRY = 3,
  parameter int CNT_W     = 16
) (
  input  logic                   dma_axi_aclk,
  input  logic                   dma_axi_aresetn,
  kernel_irq_responder_if.slave  bus
);

  // Values below the far-side synchroniser minimum would lose edges, so they
  // are raised to the minimum rather than honoured.
  localparam int PULSE_EFF = (PULSE_LEN < MIN_PULSE_LEN) ? MIN_PULSE_LEN : PULSE_LEN;
  localparam int GAP_EFF   = (GAP_LEN < MIN_GAP_LEN) ? MIN_GAP_LEN : GAP_LEN;
  localparam int TIMER_W   = $clog2(max3(PULSE_EFF, GAP_EFF, TIMEOUT)) + 1;
  localparam int RETRY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [TIMER_W-1:0] PULSE_LAST   = TIMER_W'(PULSE_EFF - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST     = TIMER_W'(GAP_EFF - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);
  localparam logic [RETRY_W-1:0] RETRY_ONE    = RETRY_W'(1);
  localparam logic [CNT_W-1:0]   COUNT_ONE    = CNT_W'(1);

  state_t               state;
  logic [TIMER_W-1:0]   timer;
  logic [RETRY_W-1:0]   retry_cnt;
  logic                 dma_pend;
  logic                 pend_consume;
  logic                 irq_s;
  logic                 dma_ack_q;
  logic                 kernel_ack_q;
  logic                 busy_q;
  logic                 err_q;
  logic [CNT_W-1:0]     irq_count_q;

  sync_2ff u_irq_sync (
    .clk   (dma_axi_aclk),
    .rst_n (dma_axi_aresetn),
    .d     (bus.kernel_irq),
    .q     (irq_s)
  );

  assign pend_consume = (state == WAIT_DMA) && dma_pend;

  // Remember a DMA completion until WAIT_DMA uses it; a new completion in the
  // consuming cycle wins so it is not lost.
  always_ff @(posedge dma_axi_aclk or negedge dma_axi_aresetn) begin
    if (!dma_axi_aresetn) begin
      dma_pend <= 1'b0;
    end else if (bus.dma_done) begin
      dma_pend <= 1'b1;
    end else if (pend_consume) begin
      dma_pend <= 1'b0;
    end
  end

  // Handshake sequencer; every output is a flop updated alongside the state.
  always_ff @(posedge dma_axi_aclk or negedge dma_axi_aresetn) begin
    if (!dma_axi_aresetn) begin
      state        <= IDLE;
      timer        <= '0;
      retry_cnt    <= '0;
      dma_ack_q    <= 1'b0;
      kernel_ack_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      irq_count_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (irq_s && bus.enable) begin
            state     <= WAIT_DMA;
            retry_cnt <= '0;
            busy_q    <= 1'b1;
          end
        end
        WAIT_DMA: begin
          if (dma_pend) begin
            state     <= DMA_ACK;
            timer     <= '0;
            dma_ack_q <= 1'b1;
          end
        end
        DMA_ACK: begin
          if (timer == PULSE_LAST) begin
            state     <= GAP;
            timer     <= '0;
            dma_ack_q <= 1'b0;
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end
        GAP: begin
          if (timer == GAP_LAST) begin
            state        <= KERN_ACK;
            timer        <= '0;
            kernel_ack_q <= 1'b1;
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end
        KERN_ACK: begin
          if (timer == PULSE_LAST) begin
            state        <= WAIT_CLR;
            timer        <= '0;
            kernel_ack_q <= 1'b0;
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end
        WAIT_CLR: begin
          if (!irq_s) begin
            state       <= IDLE;
            busy_q      <= 1'b0;
            irq_count_q <= irq_count_q + COUNT_ONE;
          end else if (timer == TIMEOUT_LAST) begin
            // The aggregator drops its DMA-ack flag on every kernel_ack
            // edge, so a retry must resend the whole pair.
            if (retry_cnt < RETRY_LIMIT) begin
              state     <= DMA_ACK;
              timer     <= '0;
              retry_cnt <= retry_cnt + RETRY_ONE;
              dma_ack_q <= 1'b1;
            end else begin
              state  <= ERROR;
              busy_q <= 1'b0;
              err_q  <= 1'b1;
            end
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end
        ERROR: begin
          if (bus.err_clr) begin
            state <= IDLE;
            err_q <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          timer        <= '0;
          dma_ack_q    <= 1'b0;
          kernel_ack_q <= 1'b0;
          busy_q       <= 1'b0;
          err_q        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dma_ack    = dma_ack_q;
  assign bus.kernel_ack = kernel_ack_q;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;
  assign bus.irq_count  = irq_count_q;

endmodule

// File: tb/tb_kernel_irq_responder.sv
// Directed bench for kernel_irq_responder with a timeline-based reference
// model checked every cycle, plus literal spot checks.
module tb_kernel_irq_responder;

  localparam int P  = 4;
  localparam int G  = 4;
  localparam int T  = 64;
  localparam int R  = 3;
  localparam int CW = 2;
  localparam int SEQ_LEN = 2 * P + G;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  kernel_irq_responder_if #(.CNT_W(CW)) bus ();

  kernel_irq_responder #(
    .PULSE_LEN (P),
    .GAP_LEN   (G),
    .TIMEOUT   (T),
    .MAX_RETRY (R),
    .CNT_W     (CW)
  ) dut (
    .dma_axi_aclk    (clk),
    .dma_axi_aresetn (rst_n),
    .bus             (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an attempt is an age counted from the first dma_ack
  // cycle; outputs follow from where that age falls in the ack timeline.
  logic          m_busy;
  logic          m_err;
  logic          m_wait_dma;
  logic          m_pend;
  logic [1:0]    m_sync;
  int            m_age;
  int            m_tries;
  logic [CW-1:0] m_count;

  always @(posedge clk or negedge rst_n) begin
    logic s_old;
    logic consume;
    if (!rst_n) begin
      m_busy = 0; m_err = 0; m_wait_dma = 0; m_pend = 0;
      m_sync = 2'b00; m_age = 0; m_tries = 0; m_count = '0;
    end else begin
      s_old   = m_sync[1];
      consume = 0;
      if (m_err) begin
        if (bus.err_clr) m_err = 0;
      end else if (!m_busy) begin
        if (s_old && bus.enable) begin
          m_busy = 1; m_wait_dma = 1; m_tries = 0;
        end
      end else if (m_wait_dma) begin
        if (m_pend) begin
          consume = 1; m_wait_dma = 0; m_age = 0;
        end
      end else if (m_age < SEQ_LEN) begin
        m_age = m_age + 1;
      end else if (!s_old) begin
        m_busy = 0; m_count = m_count + 1'b1;
      end else if (m_age - SEQ_LEN == T - 1) begin
        if (m_tries < R) begin
          m_tries = m_tries + 1; m_age = 0;
        end else begin
          m_busy = 0; m_err = 1;
        end
      end else begin
        m_age = m_age + 1;
      end
      if (bus.dma_done) m_pend = 1;
      else if (consume) m_pend = 0;
      m_sync = {m_sync[0], bus.kernel_irq};
    end
  end

  function automatic logic expDmaAck();
    return m_busy && !m_wait_dma && (m_age < P);
  endfunction

  function automatic logic expKernelAck();
    return m_busy && !m_wait_dma && (m_age >= P + G) && (m_age < SEQ_LEN);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    vectors++;
    if (actual !== required) begin
      miscompares++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, required, $time);
    end
  endtask

  // Every cycle, away from the active edge, compare the DUT against the model.
  always @(negedge clk) begin
    checkOutput("model dma_ack",    32'(bus.dma_ack),    32'(expDmaAck()));
    checkOutput("model kernel_ack", 32'(bus.kernel_ack), 32'(expKernelAck()));
    checkOutput("model busy",       32'(bus.busy),       32'(m_busy));
    checkOutput("model err",        32'(bus.err),        32'(m_err));
    checkOutput("model irq_count",  32'(bus.irq_count),  32'(m_count));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic en, input logic irq,
                               input logic done, input logic clr);
    bus.enable     = en;
    bus.kernel_irq = irq;
    bus.dma_done   = done;
    bus.err_clr    = clr;
  endtask

  task automatic pulseDmaDone();
    bus.dma_done = 1'b1;
    tick(1);
    bus.dma_done = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    for (int c = 0; c < 300; c++) begin
      tick(1);
      if (!bus.busy) break;
    end
    if (bus.busy) checkOutput({name, " idle timeout"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [CW-1:0] wrap_exp [5];
    int n_dma;
    int n_k;
    logic prev_d;
    logic prev_k;

    vectors = 0;
    miscompares = 0;
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    checkOutput("reset dma_ack",    32'(bus.dma_ack),    32'd0);
    checkOutput("reset kernel_ack", 32'(bus.kernel_ack), 32'd0);
    checkOutput("reset busy",       32'(bus.busy),       32'd0);
    checkOutput("reset err",        32'(bus.err),        32'd0);
    checkOutput("reset irq_count",  32'(bus.irq_count),  32'd0);

    // Basic service, enable dropped mid-sequence must not abort it.
    bus.enable = 1'b1;
    pulseDmaDone();
    bus.kernel_irq = 1'b1;
    tick(3);  checkOutput("basic dma_ack@3",    32'(bus.dma_ack),    32'd0);
    tick(1);  checkOutput("basic dma_ack@4",    32'(bus.dma_ack),    32'd1);
    tick(3);  checkOutput("basic dma_ack@7",    32'(bus.dma_ack),    32'd1);
    bus.enable = 1'b0;
    tick(1);  checkOutput("basic dma_ack@8",    32'(bus.dma_ack),    32'd0);
    tick(3);  checkOutput("basic kernel_ack@11", 32'(bus.kernel_ack), 32'd0);
    tick(1);  checkOutput("basic kernel_ack@12", 32'(bus.kernel_ack), 32'd1);
    tick(3);  checkOutput("basic kernel_ack@15", 32'(bus.kernel_ack), 32'd1);
    tick(1);  checkOutput("basic kernel_ack@16", 32'(bus.kernel_ack), 32'd0);
    checkOutput("basic busy@16", 32'(bus.busy), 32'd1);
    tick(4);
    bus.kernel_irq = 1'b0;
    tick(4);
    checkOutput("basic irq_count@24", 32'(bus.irq_count), 32'd1);
    checkOutput("basic busy@24",      32'(bus.busy),      32'd0);
    bus.enable = 1'b1;

    // DMA completes long after the interrupt.
    bus.kernel_irq = 1'b1;
    tick(55);
    checkOutput("late busy while waiting",    32'(bus.busy),    32'd1);
    checkOutput("late no ack while waiting",  32'(bus.dma_ack), 32'd0);
    pulseDmaDone();
    checkOutput("late dma_ack one after done", 32'(bus.dma_ack), 32'd0);
    tick(1);
    checkOutput("late dma_ack two after done", 32'(bus.dma_ack), 32'd1);
    tick(16);
    bus.kernel_irq = 1'b0;
    waitIdle("late");
    checkOutput("late irq_count", 32'(bus.irq_count), 32'd2);

    // Interrupt never clears: four ack pairs then ERROR.
    pulseDmaDone();
    bus.kernel_irq = 1'b1;
    n_dma = 0; n_k = 0; prev_d = 0; prev_k = 0;
    for (int c = 0; c < 600 && !bus.err; c++) begin
      tick(1);
      if (bus.dma_ack && !prev_d) n_dma++;
      if (bus.kernel_ack && !prev_k) n_k++;
      prev_d = bus.dma_ack;
      prev_k = bus.kernel_ack;
    end
    checkOutput("retry err set",         32'(bus.err),       32'd1);
    checkOutput("retry dma_ack pairs",   32'(n_dma),         32'd4);
    checkOutput("retry kernel_ack pairs", 32'(n_k),          32'd4);
    checkOutput("retry irq_count held",  32'(bus.irq_count), 32'd2);
    checkOutput("retry busy in error",   32'(bus.busy),      32'd0);
    tick(5);
    checkOutput("retry err sticky",      32'(bus.err),       32'd1);
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    checkOutput("err_clr err",  32'(bus.err),  32'd0);
    checkOutput("err_clr busy", 32'(bus.busy), 32'd0);
    tick(1);
    checkOutput("err_clr restart busy", 32'(bus.busy), 32'd1);
    pulseDmaDone();
    tick(1);
    checkOutput("err_clr restart dma_ack", 32'(bus.dma_ack), 32'd1);
    tick(16);
    bus.kernel_irq = 1'b0;
    waitIdle("restart");
    checkOutput("restart irq_count", 32'(bus.irq_count), 32'd3);

    // Completion arriving on the consume cycle is kept for the next interrupt.
    pulseDmaDone();
    bus.kernel_irq = 1'b1;
    tick(3);
    bus.dma_done = 1'b1;
    tick(1);
    bus.dma_done = 1'b0;
    checkOutput("double first dma_ack", 32'(bus.dma_ack), 32'd1);
    tick(15);
    bus.kernel_irq = 1'b0;
    waitIdle("double first");
    checkOutput("double irq_count wrap", 32'(bus.irq_count), 32'd0);
    bus.kernel_irq = 1'b1;
    tick(4);
    checkOutput("double second dma_ack", 32'(bus.dma_ack), 32'd1);
    tick(12);
    bus.kernel_irq = 1'b0;
    waitIdle("double second");
    checkOutput("double second irq_count", 32'(bus.irq_count), 32'd1);

    // Asynchronous reset in the middle of kernel_ack.
    pulseDmaDone();
    bus.kernel_irq = 1'b1;
    tick(13);
    checkOutput("pre-reset kernel_ack", 32'(bus.kernel_ack), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset kernel_ack", 32'(bus.kernel_ack), 32'd0);
    checkOutput("async reset busy",       32'(bus.busy),       32'd0);
    checkOutput("async reset irq_count",  32'(bus.irq_count),  32'd0);
    bus.kernel_irq = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    checkOutput("post-reset busy",      32'(bus.busy),      32'd0);
    checkOutput("post-reset irq_count", 32'(bus.irq_count), 32'd0);

    // Counter wrap; the first interrupt is already high when enable rises.
    bus.enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pulseDmaDone();
      bus.kernel_irq = 1'b1;
      if (i == 0) begin
        tick(10);
        checkOutput("irq before enable busy", 32'(bus.busy), 32'd0);
        bus.enable = 1'b1;
      end
      tick(20);
      bus.kernel_irq = 1'b0;
      waitIdle("wrap");
      checkOutput($sformatf("wrap irq_count %0d", i), 32'(bus.irq_count), 32'(wrap_exp[i]));
    end

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
